// File: rtl/zmenu_nav_ctrl.sv
`default_nettype none
// ============================================================================
// zmenu_nav_ctrl : wrapping menu cursor with auto-repeat, radio-style commits
// Rev 1.0
// ============================================================================
module zmenu_nav_ctrl #(
    parameter int NUM_ITEMS     = 11,
    parameter int IDX_W         = 4,
    parameter int NUM_GROUPS    = 2,
    parameter int GRP_W         = 2,
    parameter int SEL_W         = 3,
    parameter logic [NUM_ITEMS*GRP_W-1:0] ITEM_GROUP = {
        2'd2, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2},
    parameter logic [NUM_ITEMS*SEL_W-1:0] ITEM_VALUE = {
        3'd0, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0},
    parameter int HOLD_CYCLES   = 5_000_000,
    parameter int REPEAT_CYCLES = 1_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [3:0]                   iButton,
    output logic [IDX_W-1:0]             oCursor_Index,
    output logic [NUM_GROUPS*SEL_W-1:0]  oSel,
    output logic                         oCommit,
    output logic [GRP_W-1:0]             oCommit_Group
);

    localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic                          dir_q, dir_d;       // 0 = Prev, 1 = Next
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [3:0]                    btn_d_q;
    logic [IDX_W-1:0]              cursor_q, cursor_d;
    logic [IDX_W-1:0]              last_q, last_d;
    logic [NUM_GROUPS*SEL_W-1:0]   sel_q, sel_d;
    logic                          commit_q, commit_d;
    logic [GRP_W-1:0]              grp_q, grp_d;

    logic [3:0]       press;
    logic             held;
    logic             tick;
    logic             step_prev;
    logic             step_next;
    logic [GRP_W-1:0] item_grp;
    logic [SEL_W-1:0] item_val;

    assign press    = iButton & ~btn_d_q;
    assign held     = dir_q ? iButton[1] : iButton[0];
    assign item_grp = ITEM_GROUP[cursor_q*GRP_W +: GRP_W];
    assign item_val = ITEM_VALUE[cursor_q*SEL_W +: SEL_W];

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        tick    = 1'b0;
        if (press[0]) begin
            state_d = S_HOLD;
            dir_d   = 1'b0;
            cnt_d   = '0;
        end else if (press[1]) begin
            state_d = S_HOLD;
            dir_d   = 1'b1;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (!held) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        tick    = 1'b1;
                        state_d = S_REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_REPEAT: begin
                    if (!held) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
                        tick  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        if (!en) begin
            state_d = S_IDLE;
            dir_d   = 1'b0;
            cnt_d   = '0;
        end
    end

    assign step_prev = press[0] | (tick & ~dir_q);
    assign step_next = press[1] | (tick & dir_q);

    // Single action per cycle: Prev > Next > Okay > Cancel
    always_comb begin
        cursor_d = cursor_q;
        last_d   = last_q;
        sel_d    = sel_q;
        commit_d = 1'b0;
        grp_d    = grp_q;
        if (step_prev) begin
            cursor_d = (cursor_q == '0) ? IDX_W'(NUM_ITEMS - 1) : cursor_q - IDX_W'(1);
        end else if (step_next) begin
            cursor_d = (cursor_q == IDX_W'(NUM_ITEMS - 1)) ? '0 : cursor_q + IDX_W'(1);
        end else if (press[2]) begin
            if (int'(item_grp) < NUM_GROUPS) begin
                for (int k = 0; k < NUM_GROUPS; k++) begin
                    if (item_grp == GRP_W'(k)) begin
                        sel_d[k*SEL_W +: SEL_W] = item_val;
                    end
                end
                commit_d = 1'b1;
                grp_d    = item_grp;
                last_d   = cursor_q;
            end
        end else if (press[3]) begin
            cursor_d = last_q;
        end
        if (!en) begin
            cursor_d = '0;
            last_d   = '0;
            sel_d    = '0;
            commit_d = 1'b0;
            grp_d    = '0;
        end
    end

    // The edge register keeps tracking while disabled so a held button is not a press on enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dir_q    <= 1'b0;
            cnt_q    <= '0;
            btn_d_q  <= '0;
            cursor_q <= '0;
            last_q   <= '0;
            sel_q    <= '0;
            commit_q <= 1'b0;
            grp_q    <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            btn_d_q  <= iButton;
            cursor_q <= cursor_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            commit_q <= commit_d;
            grp_q    <= grp_d;
        end
    end

    assign oCursor_Index = cursor_q;
    assign oSel          = sel_q;
    assign oCommit       = commit_q;
    assign oCommit_Group = grp_q;

endmodule
`default_nettype wire

// File: tb/tb_zmenu_nav_ctrl.sv
`default_nettype none
// ============================================================================
// tb_zmenu_nav_ctrl : scoreboard bench for the menu cursor controller
// Rev 1.0
// ============================================================================
module tb_zmenu_nav_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] iButton;
    logic [3:0] oCursor_Index;
    logic [5:0] oSel;
    logic       oCommit;
    logic [1:0] oCommit_Group;

    zmenu_nav_ctrl #(
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .iButton      (iButton),
        .oCursor_Index(oCursor_Index),
        .oSel         (oSel),
        .oCommit      (oCommit),
        .oCommit_Group(oCommit_Group)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] idx;
        logic [5:0] sel;
        logic [1:0] grp;
    } state_exp_t;

    typedef struct {
        logic [1:0] grp;
        logic [5:0] sel;
    } commit_exp_t;

    state_exp_t  st_q[$];
    commit_exp_t cm_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;

    logic [5:0] es   = '0;
    logic [1:0] egrp = '0;
    logic [3:0] eidx = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: oCommit acts as the valid for commit events; state snapshots are cycle-tagged
    always @(posedge clk) begin
        #1;
        if (oCommit) begin
            if (cm_q.size() == 0) begin
                chk("unexpected_commit", 1, 0);
            end else begin
                commit_exp_t c;
                c = cm_q.pop_front();
                chk("commit_group", int'(oCommit_Group), int'(c.grp));
                chk("commit_sel", int'(oSel), int'(c.sel));
            end
        end
        while (st_q.size() > 0 && st_q[0].cyc <= cyc_cnt) begin
            state_exp_t s;
            s = st_q.pop_front();
            if (s.cyc < cyc_cnt) begin
                chk("stale_expectation", s.cyc, cyc_cnt);
            end else begin
                chk("cursor", int'(oCursor_Index), int'(s.idx));
                chk("sel", int'(oSel), int'(s.sel));
                chk("commit_group_held", int'(oCommit_Group), int'(s.grp));
            end
        end
    end

    // Drive a vector at the falling edge and record the state expected after the next rising edge
    task automatic drive(input logic e, input logic [3:0] b);
        @(negedge clk);
        en      = e;
        iButton = b;
    endtask

    task automatic expect_state();
        state_exp_t s;
        s.cyc = cyc_cnt + 1;
        s.idx = eidx;
        s.sel = es;
        s.grp = egrp;
        st_q.push_back(s);
    endtask

    task automatic expect_commit();
        commit_exp_t c;
        c.grp = egrp;
        c.sel = es;
        cm_q.push_back(c);
    endtask

    task automatic tap(input logic [3:0] b, input logic [3:0] idx_after);
        drive(1'b1, b);
        eidx = idx_after;
        expect_state();
        drive(1'b1, 4'b0000);
        expect_state();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        iButton = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'b0000);
        expect_state();

        // Wrap in both directions
        tap(4'b0001, 4'd10);
        tap(4'b0010, 4'd0);

        // Auto-repeat: step at press, after 8 cycles, then every 4
        for (int k = 0; k <= 20; k++) begin
            drive(1'b1, 4'b0010);
            eidx = 4'd1 + 4'(k >= 8) + 4'(k >= 12) + 4'(k >= 16) + 4'(k >= 20);
            expect_state();
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 4'b0000);
            expect_state();
        end

        // Commit at item 3 (group 0, value 2)
        tap(4'b0001, 4'd4);
        tap(4'b0001, 4'd3);
        es[2:0] = 3'd2;
        egrp    = 2'd0;
        drive(1'b1, 4'b0100);
        expect_state();
        expect_commit();
        drive(1'b1, 4'b0000);
        expect_state();

        // Non-selectable item 6
        tap(4'b0010, 4'd4);
        tap(4'b0010, 4'd5);
        tap(4'b0010, 4'd6);
        tap(4'b0100, 4'd6);

        // Commit at 7 (group 1, value 1), wander to 2, Cancel back to 7
        tap(4'b0010, 4'd7);
        es[5:3] = 3'd1;
        egrp    = 2'd1;
        drive(1'b1, 4'b0100);
        expect_state();
        expect_commit();
        drive(1'b1, 4'b0000);
        expect_state();
        for (int k = 6; k >= 2; k--) tap(4'b0001, 4'(k));
        tap(4'b1000, 4'd7);

        // Prev and Okay together: only the step happens
        tap(4'b0101, 4'd6);

        // Drop en in the REPEAT phase
        for (int k = 0; k <= 9; k++) begin
            drive(1'b1, 4'b0010);
            eidx = 4'd7 + 4'(k >= 8);
            expect_state();
        end
        es = '0; egrp = '0; eidx = '0;
        drive(1'b0, 4'b0010);
        expect_state();
        drive(1'b0, 4'b0010);
        expect_state();
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 4'b0010);
            expect_state();
        end
        drive(1'b1, 4'b0000);
        expect_state();

        // Commit at item 9 (group 1, value 3), then hold Prev and reset asynchronously
        tap(4'b0001, 4'd10);
        tap(4'b0001, 4'd9);
        es[5:3] = 3'd3;
        egrp    = 2'd1;
        drive(1'b1, 4'b0100);
        expect_state();
        expect_commit();
        drive(1'b1, 4'b0001);
        eidx = 4'd8;
        expect_state();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'b0001);
            expect_state();
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_cursor", int'(oCursor_Index), 0);
        chk("async_sel", int'(oSel), 0);
        chk("async_commit", int'(oCommit), 0);
        chk("async_group", int'(oCommit_Group), 0);
        es = '0; egrp = '0; eidx = '0;
        @(negedge clk);
        iButton = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 4'b0000);
            expect_state();
        end
        tap(4'b0010, 4'd1);

        repeat (3) @(negedge clk);
        chk("pending_state_checks", st_q.size(), 0);
        chk("pending_commits", cm_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
